// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Adds two SLICE_W*NUM_SLICES-bit operands plus a carry-in over NUM_SLICES cycles. A single
//   SLICE_W-bit carry-look-ahead slice is reused on each cycle, and the carry between slices is
//   held in a register.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i / ready_o    request handshake; a_i, b_i, cin_i are sampled on accept
//   valid_o / ready_i    result handshake; sum_o, cout_o, ovf_o are held while valid_o=1
//   busy_o               high while slices are being added
module wide_add_sequencer #(
    parameter int unsigned SLICE_W    = 32,
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [SLICE_W*NUM_SLICES-1:0] a_i,
    input  logic [SLICE_W*NUM_SLICES-1:0] b_i,
    input  logic                          cin_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [SLICE_W*NUM_SLICES-1:0] sum_o,
    output logic                          cout_o,
    output logic                          ovf_o,
    output logic                          busy_o
);

    localparam int unsigned N      = SLICE_W * NUM_SLICES;
    localparam int unsigned IdxW   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int unsigned NumGrp = SLICE_W / 4;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IdxW-1:0] idx_q, idx_d;

    // Shared adder slice
    logic [SLICE_W-1:0] sl_a, sl_b, sl_g, sl_p, sl_sum;
    logic [SLICE_W:0]   sl_c;
    logic [3:0]         gg, pp;
    logic               ci;

    assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

    // 4-bit look-ahead groups; group carries chain from one group to the next.
    always_comb begin
        sl_g    = sl_a & sl_b;
        sl_p    = sl_a ^ sl_b;
        sl_c    = '0;
        sl_c[0] = c_q;
        gg      = '0;
        pp      = '0;
        ci      = 1'b0;
        for (int grp = 0; grp < NumGrp; grp++) begin
            gg = sl_g[4*grp +: 4];
            pp = sl_p[4*grp +: 4];
            ci = sl_c[4*grp];
            sl_c[4*grp+1] = gg[0] | (pp[0] & ci);
            sl_c[4*grp+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
            sl_c[4*grp+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                          | (pp[2] & pp[1] & pp[0] & ci);
            sl_c[4*grp+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                          | (pp[3] & pp[2] & pp[1] & gg[0])
                          | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
        end
        sl_sum = sl_p ^ sl_c[SLICE_W-1:0];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    c_d     = cin_i;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
                if (idx_q == IdxW'(NUM_SLICES - 1)) begin
                    cout_d  = sl_c[SLICE_W];
                    // The top-slice sum is not in sum_q yet, so its MSB is taken from the adder.
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (sl_sum[SLICE_W-1] != a_q[N-1]);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    c_d   = sl_c[SLICE_W];
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign ready_o = (state_q == StIdle);
    assign busy_o  = (state_q == StRun);
    assign valid_o = (state_q == StDone);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer
//   Scoreboard bench. The driver pushes the reference result at accept. A monitor pops that
//   result and compares it at each result handshake. The monitor also checks accept-to-valid
//   latency, the busy duration and ready_o after handoff.
module tb_wide_add_sequencer;

    localparam int unsigned SLICE_W    = 32;
    localparam int unsigned NUM_SLICES = 4;
    localparam int unsigned N          = SLICE_W * NUM_SLICES;
    localparam int unsigned W          = N + 2;

    logic         clk, rst_ni, valid_i, ready_o, cin_i, valid_o, ready_i, cout_o, ovf_o, busy_o;
    logic [N-1:0] a_i, b_i, sum_o;

    typedef struct {
        logic [W-1:0] exp;
        int           acc;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rmode = 2;  // 0: random ready_i, 1: hold low, 2: hold high

    wide_add_sequencer #(
        .SLICE_W   (SLICE_W),
        .NUM_SLICES(NUM_SLICES)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .sum_o  (sum_o),
        .cout_o (cout_o),
        .ovf_o  (ovf_o),
        .busy_o (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain (N+1)-bit arithmetic, packed as {cout, ovf, sum}.
    function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic c);
        logic [N:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
        return {full[N], ovf, full[N-1:0]};
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < (N + 31) / 32; i++) r = (r << 32) | N'($urandom);
        return r;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_ready", W'(ready_o), 1);
        chk("rst_valid", W'(valid_o), 0);
        chk("rst_busy", W'(busy_o), 0);
        chk("rst_sum", W'(sum_o), 0);
        chk("rst_cout", W'(cout_o), 0);
        chk("rst_ovf", W'(ovf_o), 0);
    endtask

    // Presents a request until it is accepted, then scrambles the operand inputs.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         input bit push, input int nscr);
        int w;
        bit ok;
        ent_t e;
        w  = 0;
        ok = 0;
        a_i = a;
        b_i = b;
        cin_i = c;
        valid_i = 1'b1;
        while (!ok && w < 200) begin
            @(negedge clk);
            if (ready_o) begin
                @(posedge clk);
                #1;
                ok = 1;
            end else begin
                w++;
            end
        end
        valid_i = 1'b0;
        chk("accept", W'(ok), 1);
        if (ok && push) begin
            e.exp = model(a, b, c);
            e.acc = cyc;
            sb.push_back(e);
        end
        for (int i = 0; i < nscr; i++) begin
            a_i   = rand_n();
            b_i   = rand_n();
            cin_i = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain", W'(sb.size()), 0);
    endtask

    // ready_i driver
    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       ready_i = ($urandom_range(0, 3) != 0);
                1:       ready_i = 1'b0;
                default: ready_i = 1'b1;
            endcase
        end
    end

    // Monitor
    initial begin
        bit   prev_valid;
        bit   after_hs;
        int   busy_run;
        ent_t e;
        prev_valid = 0;
        after_hs   = 0;
        busy_run   = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_valid = 0;
                after_hs   = 0;
                busy_run   = 0;
            end else begin
                if (after_hs) begin
                    chk("ready_after_handoff", W'({ready_o, valid_o}), W'(2'b10));
                    after_hs = 0;
                end
                if (busy_o) busy_run++;
                if (valid_o && !prev_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", W'(valid_o), 0);
                    end else begin
                        chk("latency", W'(cyc - sb[0].acc), W'(NUM_SLICES));
                        chk("busy_cycles", W'(busy_run), W'(NUM_SLICES));
                    end
                    busy_run = 0;
                end
                if (valid_o && ready_i && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("result", {cout_o, ovf_o, sum_o}, e.exp);
                    after_hs = 1;
                end
                prev_valid = valid_o;
            end
        end
    end

    // Stimulus
    initial begin
        logic [N-1:0] a, b;
        logic [W-1:0] exp_bp;
        int           w;
        int           sel;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        cin_i   = 1'b0;
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Carry ripples across every slice: (2^N-1) + 1
        rmode = 2;
        issue('1, N'(1), 1'b0, 1, NUM_SLICES);
        // Signed overflow: max positive + 1 + cin
        a = {1'b0, {(N-1){1'b1}}};
        issue(a, N'(1), 1'b1, 1, NUM_SLICES);
        drain();

        // Backpressure: result held for 10 cycles, a new request is ignored
        rmode = 1;
        a = rand_n();
        b = rand_n();
        exp_bp = model(a, b, 1'b1);
        issue(a, b, 1'b1, 1, NUM_SLICES);
        w = 0;
        while (!valid_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", W'(valid_o), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'b1;
            a_i     = rand_n();
            b_i     = rand_n();
            cin_i   = 1'($urandom);
            @(negedge clk);
            chk("bp_ready_valid", W'({ready_o, valid_o}), W'(2'b01));
            chk("bp_result_stable", {cout_o, ovf_o, sum_o}, exp_bp);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rmode   = 2;
        drain();

        // Reset while idx_q == 2: the aborted operation must never show valid_o
        issue(rand_n(), rand_n(), 1'b1, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        issue(N'(5), N'(7), 1'b0, 1, NUM_SLICES);
        drain();

        // Randomized traffic with random consumer backpressure
        rmode = 0;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 4);
            a   = rand_n();
            case (sel)
                0:       b = rand_n();
                1:       begin a = '1; b = N'($urandom_range(0, 3)); end
                2:       b = ~a;
                3:       begin a = {1'b1, a[N-2:0]}; b = {1'b1, rand_n() >> 1}; end
                default: begin a = '0; b = '0; end
            endcase
            issue(a, b, 1'($urandom), 1, $urandom_range(0, NUM_SLICES));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
